vending_change_dispenser: RTL and testbench

- Payout side of the vending machine: takes a change/refund amount in nickel units and pays it out through the coin mechanism as individual dime and nickel eject requests.
- Dimes are paid first, then nickels.
- Tracks the on-board coin inventory, handles the eject/ack handshake with the mechanism, and flags short payment or mechanism faults.
- Sits between the credit/vend controller (issues req) and the physical coin hopper (consumes eject_*, returns mech_ack).

---
 rtl/vending_change_dispenser.sv | 171 +++++++++++++++++
 tb/tb_vending_change_dispenser.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_change_dispenser.sv
// Change dispenser: pays a nickel-unit amount out as dime/nickel eject
// requests (dimes first), tracks coin inventory and reports short/fault.
module vending_change_dispenser #(
  parameter int AMT_W       = 5,
  parameter int CNT_W       = 8,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             mech_ack,
  input  logic             refill_nickel,
  input  logic             refill_dime,
  output logic             busy,
  output logic             eject_nickel,
  output logic             eject_dime,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [AMT_W-1:0] unpaid,
  output logic [CNT_W-1:0] nickel_count,
  output logic [CNT_W-1:0] dime_count,
  output logic [2:0]       currentState
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECIDE   = 3'd1,
    S_EJECT    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               coin_q, coin_d;     // 1 = dime, 0 = nickel
  logic               short_q, short_d;
  logic               fault_q, fault_d;
  logic [AMT_W-1:0]   unpaid_q, unpaid_d;
  logic [CNT_W-1:0]   nickel_q, nickel_d;
  logic [CNT_W-1:0]   dime_q, dime_d;
  logic               nick_dec, dime_dec;

  // State, payout bookkeeping and inventory registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      timer_q  <= '0;
      coin_q   <= 1'b0;
      short_q  <= 1'b0;
      fault_q  <= 1'b0;
      unpaid_q <= '0;
      nickel_q <= CNT_W'(NICKEL_INIT);
      dime_q   <= CNT_W'(DIME_INIT);
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      timer_q  <= timer_d;
      coin_q   <= coin_d;
      short_q  <= short_d;
      fault_q  <= fault_d;
      unpaid_q <= unpaid_d;
      nickel_q <= nickel_d;
      dime_q   <= dime_d;
    end
  end

  // Next state: coin choice, ack wait with timeout, result capture on entry to DONE
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    timer_d  = timer_q;
    coin_d   = coin_q;
    short_d  = short_q;
    fault_d  = fault_q;
    unpaid_d = unpaid_q;
    nick_dec = 1'b0;
    dime_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rem_d    = req_amount;
          short_d  = 1'b0;
          fault_d  = 1'b0;
          unpaid_d = '0;
          state_d  = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (rem_q == '0) begin
          short_d  = 1'b0;
          fault_d  = 1'b0;
          unpaid_d = '0;
          state_d  = S_DONE;
        end else if (rem_q >= AMT_W'(2) && dime_q != '0) begin
          coin_d  = 1'b1;
          state_d = S_EJECT;
        end else if (nickel_q != '0) begin
          coin_d  = 1'b0;
          state_d = S_EJECT;
        end else begin
          // Nothing left that fits the balance: report what is still owed
          short_d  = 1'b1;
          fault_d  = 1'b0;
          unpaid_d = rem_q;
          state_d  = S_DONE;
        end
      end
      S_EJECT: begin
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (mech_ack) begin
          if (coin_q) begin
            dime_dec = 1'b1;
            rem_d    = rem_q - AMT_W'(2);
          end else begin
            nick_dec = 1'b1;
            rem_d    = rem_q - AMT_W'(1);
          end
          state_d = S_DECIDE;
        end else if (timer_q == TMR_LAST) begin
          // Coin never confirmed: it is not counted as paid
          short_d  = 1'b1;
          fault_d  = 1'b1;
          unpaid_d = rem_q;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Inventory: saturating refill, acked decrement; both at once cancel out
  always_comb begin
    nickel_d = nickel_q;
    dime_d   = dime_q;
    if (refill_nickel && !nick_dec)
      nickel_d = (&nickel_q) ? nickel_q : nickel_q + CNT_W'(1);
    else if (nick_dec && !refill_nickel)
      nickel_d = nickel_q - CNT_W'(1);
    if (refill_dime && !dime_dec)
      dime_d = (&dime_q) ? dime_q : dime_q + CNT_W'(1);
    else if (dime_dec && !refill_dime)
      dime_d = dime_q - CNT_W'(1);
  end

  assign busy         = (state_q != S_IDLE);
  assign eject_dime   = (state_q == S_EJECT) &&  coin_q;
  assign eject_nickel = (state_q == S_EJECT) && !coin_q;
  assign done         = (state_q == S_DONE);
  assign short        = short_q;
  assign fault        = fault_q;
  assign unpaid       = unpaid_q;
  assign nickel_count = nickel_q;
  assign dime_count   = dime_q;
  assign currentState = state_q;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: transaction-level payout model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_vending_change_dispenser;

  localparam int AMT_W = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             mech_ack = 1'b0;
  logic             refill_nickel = 1'b0;
  logic             refill_dime = 1'b0;
  logic             busy, eject_nickel, eject_dime, done, short, fault;
  logic [AMT_W-1:0] unpaid;
  logic [CNT_W-1:0] nickel_count, dime_count;
  logic [2:0]       currentState;

  vending_change_dispenser dut (
    .clk(clk), .rst(rst), .req(req), .req_amount(req_amount),
    .mech_ack(mech_ack), .refill_nickel(refill_nickel), .refill_dime(refill_dime),
    .busy(busy), .eject_nickel(eject_nickel), .eject_dime(eject_dime),
    .done(done), .short(short), .fault(fault), .unpaid(unpaid),
    .nickel_count(nickel_count), .dime_count(dime_count),
    .currentState(currentState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // model state: inventory, balance owed, coin ejected but not yet acked
  int mn = 20, md = 10;
  int m_active = 0, m_rem = 0, m_out = 0;
  int m_ls = 0, m_lf = 0, m_lu = 0;
  int prev_ej = 0, ej = 0, dn = 0, decn = 0, decd = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // coin the payout rules call for next: 0 none, 1 nickel, 2 dime
  function automatic int choose(input int rem, input int n, input int d);
    if (rem == 0) return 0;
    if (rem >= 2 && d > 0) return 2;
    if (n > 0) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v, input int inc, input int dec);
    if (inc != 0 && dec == 0) return (v == CMAX) ? v : v + 1;
    if (dec != 0 && inc == 0) return v - 1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // one payout; acks each coin dly cycles after its eject unless give_ack=0
  task automatic pay(input int amt, input int dly, input bit give_ack,
                     input bit refill_on_ack, input bit poke,
                     output int nd, output int nn, output int lat);
    int guard, cyc, first;
    nd = 0; nn = 0; cyc = 0; first = -1; guard = 0;
    req = 1'b1; req_amount = amt[AMT_W-1:0];
    step();
    req = 1'b0;
    while (!done && guard < 600) begin
      if (eject_dime || eject_nickel) begin
        if (eject_dime) nd++; else nn++;
        if (first < 0) first = cyc;
        if (give_ack) begin
          for (int k = 0; k < dly; k++) begin
            step(); cyc++; guard++;
            if (poke && k == 0) begin req = 1'b1; req_amount = 5'd5; end
            else req = 1'b0;
          end
          mech_ack = 1'b1; refill_nickel = refill_on_ack;
          step(); cyc++; guard++;
          mech_ack = 1'b0; refill_nickel = 1'b0; req = 1'b0;
          continue;
        end
      end
      step(); cyc++; guard++;
    end
    chk("pay_done_seen", done, 1);
    lat = cyc - first;
    step();
  endtask

  initial begin
    int nd, nn, lat;

    // per-cycle comparison against the payout model
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          mn = 20; md = 10; m_active = 0; m_rem = 0; m_out = 0;
          m_ls = 0; m_lf = 0; m_lu = 0; prev_ej = 0;
        end else begin
          chk("m_busy", busy, m_active);
          chk("m_nickels", nickel_count, mn);
          chk("m_dimes", dime_count, md);
          ej = (eject_nickel || eject_dime) ? 1 : 0;
          dn = 0;
          if (ej != 0) begin
            chk("m_eject_onehot", eject_nickel & eject_dime, 0);
            chk("m_eject_width", prev_ej, 0);
            chk("m_eject_coin", eject_dime ? 2 : 1, choose(m_rem, mn, md));
            chk("m_eject_allowed", (m_active != 0 && m_out == 0) ? 1 : 0, 1);
            m_out = eject_dime ? 2 : 1;
          end
          if (done) begin
            chk("m_done_allowed",
                (m_active != 0 && (m_out != 0 || choose(m_rem, mn, md) == 0)) ? 1 : 0, 1);
            chk("m_done_unpaid", unpaid, m_rem);
            chk("m_done_short", short, (m_rem != 0) ? 1 : 0);
            chk("m_done_fault", fault, (m_out != 0) ? 1 : 0);
            m_lu = m_rem; m_ls = (m_rem != 0) ? 1 : 0; m_lf = (m_out != 0) ? 1 : 0;
            dn = 1;
          end else if (m_active == 0) begin
            chk("m_hold_unpaid", unpaid, m_lu);
            chk("m_hold_short", short, m_ls);
            chk("m_hold_fault", fault, m_lf);
          end
          prev_ej = ej;
          // effects of the coming clock edge
          decn = 0; decd = 0;
          if (dn != 0) begin
            m_active = 0; m_out = 0;
          end else if (m_active == 0 && req) begin
            m_active = 1; m_rem = req_amount; m_out = 0;
          end else if (m_active != 0 && mech_ack && m_out != 0 && ej == 0) begin
            if (m_out == 2) begin decd = 1; m_rem -= 2; end
            else begin decn = 1; m_rem -= 1; end
            m_out = 0;
          end
          mn = sat(mn, refill_nickel, decn);
          md = sat(md, refill_dime, decd);
        end
      end
    join_none

    // reset state
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ej_n", eject_nickel, 0);
    chk("rst_ej_d", eject_dime, 0);
    chk("rst_unpaid", unpaid, 0);
    chk("rst_state", currentState, 0);
    chk("rst_nickels", nickel_count, 20);
    chk("rst_dimes", dime_count, 10);
    step();
    rst = 1'b0;

    // zero amount: DECIDE then DONE
    req = 1'b1; req_amount = '0;
    step();
    req = 1'b0;
    chk("zero_state_decide", currentState, 1);
    chk("zero_done_early", done, 0);
    step();
    chk("zero_done", done, 1);
    chk("zero_state_done", currentState, 4);
    chk("zero_short", short, 0);
    step();
    chk("zero_idle", busy, 0);

    // 3 nickels: dime then nickel
    pay(3, 2, 1'b1, 1'b0, 1'b0, nd, nn, lat);
    chk("p3_dimes_ejected", nd, 1);
    chk("p3_nickels_ejected", nn, 1);
    chk("p3_nickels", nickel_count, 19);
    chk("p3_dimes", dime_count, 9);
    chk("p3_short", short, 0);
    chk("p3_unpaid", unpaid, 0);

    // drain dimes, then 4 must go out as nickels
    do_reset();
    pay(20, 1, 1'b1, 1'b0, 1'b0, nd, nn, lat);
    chk("p20_dimes_ejected", nd, 10);
    chk("p20_dimes", dime_count, 0);
    pay(4, 1, 1'b1, 1'b0, 1'b0, nd, nn, lat);
    chk("p4_dimes_ejected", nd, 0);
    chk("p4_nickels_ejected", nn, 4);
    chk("p4_nickels", nickel_count, 16);
    chk("p4_short", short, 0);

    // drain nickels, one dime on board, odd amount ends short
    pay(16, 1, 1'b1, 1'b0, 1'b0, nd, nn, lat);
    chk("p16_nickels", nickel_count, 0);
    refill_dime = 1'b1;
    step();
    refill_dime = 1'b0;
    chk("refill_one_dime", dime_count, 1);
    pay(3, 2, 1'b1, 1'b0, 1'b0, nd, nn, lat);
    chk("short_dimes_ejected", nd, 1);
    chk("short_nickels_ejected", nn, 0);
    chk("short_flag", short, 1);
    chk("short_fault", fault, 0);
    chk("short_unpaid", unpaid, 1);
    chk("short_dimes", dime_count, 0);

    // ack timeout
    do_reset();
    pay(1, 0, 1'b0, 1'b0, 1'b0, nd, nn, lat);
    chk("to_eject_to_done", lat, 17);
    chk("to_fault", fault, 1);
    chk("to_short", short, 1);
    chk("to_unpaid", unpaid, 1);
    chk("to_nickels", nickel_count, 20);

    // refill and ack of a nickel in the same cycle
    pay(1, 2, 1'b1, 1'b1, 1'b0, nd, nn, lat);
    chk("refack_nickels", nickel_count, 20);
    chk("refack_short", short, 0);

    // req while busy is dropped
    pay(2, 3, 1'b1, 1'b0, 1'b1, nd, nn, lat);
    chk("poke_dimes_ejected", nd, 1);
    chk("poke_nickels_ejected", nn, 0);
    chk("poke_dimes", dime_count, 9);
    repeat (3) step();
    chk("poke_no_second", busy, 0);

    // dime refill saturates
    refill_dime = 1'b1;
    repeat (300) step();
    refill_dime = 1'b0;
    chk("sat_dimes", dime_count, 255);

    // async reset while waiting for an ack; a late ack is ignored
    req = 1'b1; req_amount = 5'd2;
    step();
    req = 1'b0;
    step();
    chk("ar_eject", eject_dime, 1);
    step();
    step();
    chk("ar_waiting", currentState, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ej_d", eject_dime, 0);
    chk("ar_done", done, 0);
    chk("ar_state", currentState, 0);
    chk("ar_nickels", nickel_count, 20);
    chk("ar_dimes", dime_count, 10);
    step();
    rst = 1'b0;
    mech_ack = 1'b1;
    step();
    mech_ack = 1'b0;
    step();
    chk("ar_late_ack_dimes", dime_count, 10);
    chk("ar_late_ack_state", currentState, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
